// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between N_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_rr_master_arbiter #(
   parameter int N_REQ          = 2,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      clk_i,
   input  logic                      aresetn_i,
   input  logic [N_REQ-1:0]          req_valid_i,
   output logic [N_REQ-1:0]          req_ready_o,
   input  logic [N_REQ-1:0]          req_write_i,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
   output logic [N_REQ-1:0]          resp_valid_o,
   output logic [DATA_W-1:0]         resp_rdata_o,
   output logic                      resp_slverr_o,
   output logic                      psel_o,
   output logic                      penable_o,
   output logic                      pwrite_o,
   output logic [ADDR_W-1:0]         paddr_o,
   output logic [DATA_W-1:0]         pwdata_o,
   input  logic [DATA_W-1:0]         prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_chk
      $error("apb_rr_master_arbiter: bad parameters");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [PW-1:0]       r_ptr, w_ptr_nxt;
   logic [N_REQ-1:0]    r_gnt, w_gnt_nxt;
   logic                r_psel, w_psel_nxt;
   logic                r_penable, w_penable_nxt;
   logic                r_pwrite, w_pwrite_nxt;
   logic [ADDR_W-1:0]   r_paddr, w_paddr_nxt;
   logic [DATA_W-1:0]   r_pwdata, w_pwdata_nxt;
   logic [N_REQ-1:0]    r_resp_valid, w_resp_valid_nxt;
   logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
   logic                r_slverr, w_slverr_nxt;
   logic [N_REQ-1:0]    w_ready;
   logic                w_found;
   logic [PW-1:0]       w_gidx;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]       r_tmo, w_tmo_nxt;
`endif

   function automatic logic [PW-1:0] f_wrap(input int v);
      if (v >= N_REQ) return PW'(v - N_REQ);
      return PW'(v);
   endfunction

   // First valid requester at or after the pointer, wrapping around
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && req_valid_i[f_wrap(int'(r_ptr) + k)]) begin
            w_found = 1'b1;
            w_gidx  = f_wrap(int'(r_ptr) + k);
         end
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_ptr_nxt        = r_ptr;
      w_gnt_nxt        = r_gnt;
      w_psel_nxt       = r_psel;
      w_penable_nxt    = r_penable;
      w_pwrite_nxt     = r_pwrite;
      w_paddr_nxt      = r_paddr;
      w_pwdata_nxt     = r_pwdata;
      w_resp_valid_nxt = '0;
      w_rdata_nxt      = '0;
      w_slverr_nxt     = 1'b0;
      w_ready          = '0;
`ifdef APB_ARB_TIMEOUT_EN
      w_tmo_nxt        = r_tmo;
`endif
      unique case (r_state)
         S_IDLE: begin
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
            if (w_found) begin
               w_ready         = '0;
               w_ready[w_gidx] = 1'b1;
               w_gnt_nxt       = w_ready;
               w_pwrite_nxt    = req_write_i[w_gidx];
               w_paddr_nxt     = req_addr_i[w_gidx*ADDR_W +: ADDR_W];
               w_pwdata_nxt    = req_wdata_i[w_gidx*DATA_W +: DATA_W];
               w_ptr_nxt       = f_wrap(int'(w_gidx) + 1);
               w_psel_nxt      = 1'b1;
               w_state_nxt     = S_SETUP;
            end
         end
         S_SETUP: begin
            w_penable_nxt = 1'b1;
            w_state_nxt   = S_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
            w_tmo_nxt     = '0;
`endif
         end
         S_ACCESS: begin
            if (pready_i) begin
               w_psel_nxt       = 1'b0;
               w_penable_nxt    = 1'b0;
               w_resp_valid_nxt = r_gnt;
               w_rdata_nxt      = r_pwrite ? '0 : prdata_i;
               w_slverr_nxt     = pslverr_i;
               w_state_nxt      = S_IDLE;
            end
`ifdef APB_ARB_TIMEOUT_EN
            // Last permitted wait cycle: abandon with an error response
            else if (r_tmo == CW'(TIMEOUT_CYCLES - 1)) begin
               w_psel_nxt       = 1'b0;
               w_penable_nxt    = 1'b0;
               w_resp_valid_nxt = r_gnt;
               w_slverr_nxt     = 1'b1;
               w_state_nxt      = S_IDLE;
            end else begin
               w_tmo_nxt = r_tmo + 1'b1;
            end
`endif
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!aresetn_i) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_gnt        <= '0;
         r_psel       <= 1'b0;
         r_penable    <= 1'b0;
         r_pwrite     <= 1'b0;
         r_paddr      <= '0;
         r_pwdata     <= '0;
         r_resp_valid <= '0;
         r_rdata      <= '0;
         r_slverr     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_ptr        <= w_ptr_nxt;
         r_gnt        <= w_gnt_nxt;
         r_psel       <= w_psel_nxt;
         r_penable    <= w_penable_nxt;
         r_pwrite     <= w_pwrite_nxt;
         r_paddr      <= w_paddr_nxt;
         r_pwdata     <= w_pwdata_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_rdata      <= w_rdata_nxt;
         r_slverr     <= w_slverr_nxt;
      end
   end

`ifdef APB_ARB_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (!aresetn_i) r_tmo <= '0;
      else            r_tmo <= w_tmo_nxt;
   end
`endif

   assign req_ready_o   = w_ready;
   assign resp_valid_o  = r_resp_valid;
   assign resp_rdata_o  = r_rdata;
   assign resp_slverr_o = r_slverr;
   assign psel_o        = r_psel;
   assign penable_o     = r_penable;
   assign pwrite_o      = r_pwrite;
   assign paddr_o       = r_paddr;
   assign pwdata_o      = r_pwdata;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Directed self-checking bench for apb_rr_master_arbiter.
// Timeout branch is exercised when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_rr_master_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic           clk = 1'b0;
   logic           aresetn;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   req_write;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]   resp_valid;
   logic [DW-1:0]  resp_rdata;
   logic           resp_slverr;
   logic           psel, penable, pwrite;
   logic [AW-1:0]  paddr;
   logic [DW-1:0]  pwdata;
   logic [DW-1:0]  prdata;
   logic           pready, pslverr;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   apb_rr_master_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk_i(clk), .aresetn_i(aresetn),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_write_i(req_write), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .resp_valid_o(resp_valid),
      .resp_rdata_o(resp_rdata), .resp_slverr_o(resp_slverr),
      .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
      .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata),
      .pready_i(pready), .pslverr_i(pslverr)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[i]         = wr;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 64'(req_ready), 64'd0);
      chk({tag, "_rvalid"}, 64'(resp_valid), 64'd0);
      chk({tag, "_psel"}, 64'(psel), 64'd0);
      chk({tag, "_pen"}, 64'(penable), 64'd0);
      chk({tag, "_pwrite"}, 64'(pwrite), 64'd0);
      chk({tag, "_paddr"}, 64'(paddr), 64'd0);
      chk({tag, "_pwdata"}, 64'(pwdata), 64'd0);
      chk({tag, "_rdata"}, 64'(resp_rdata), 64'd0);
      chk({tag, "_slverr"}, 64'(resp_slverr), 64'd0);
   endtask

   initial begin
      logic [DW-1:0] rd [4];
      logic          seen;
      rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33; rd[3] = 32'h44;
      aresetn = 1'b0; req_valid = '0; req_write = '0;
      req_addr = '0; req_wdata = '0;
      prdata = '0; pready = 1'b0; pslverr = 1'b0;
      tick(); tick();
      chk_all_zero("rst");
      aresetn = 1'b1;

      // Single write from req0, zero wait states
      set_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
      req_valid = 2'b01; pready = 1'b1; #1;
      chk("w_ready_c0", 64'(req_ready), 64'h1);
      tick(); req_valid = 2'b00;
      chk("w_setup_psel", 64'({psel, penable}), 64'h2);
      chk("w_paddr", 64'(paddr), 64'h10);
      chk("w_pwrite", 64'(pwrite), 64'h1);
      chk("w_pwdata", 64'(pwdata), 64'hA5A5_0001);
      chk("w_rvalid_c1", 64'(resp_valid), 64'h0);
      tick();
      chk("w_access", 64'({psel, penable}), 64'h3);
      tick();
      chk("w_rvalid_c3", 64'(resp_valid), 64'h1);
      chk("w_slverr", 64'(resp_slverr), 64'h0);
      chk("w_rdata", 64'(resp_rdata), 64'h0);
      chk("w_idle", 64'({psel, penable}), 64'h0);
      tick();
      chk("w_rvalid_c4", 64'(resp_valid), 64'h0);

      // Reset returns the pointer to 0 before the fairness test
      aresetn = 1'b0; tick(); aresetn = 1'b1;

      set_req(0, 1'b0, 32'h100, 32'h0);
      set_req(1, 1'b0, 32'h200, 32'h0);
      req_valid = 2'b11; pready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         #1;
         chk($sformatf("rr_ready%0d", t), 64'(req_ready), 64'(1 << (t % 2)));
         tick();
         chk($sformatf("rr_paddr%0d", t), 64'(paddr),
             (t % 2) ? 64'h200 : 64'h100);
         tick();
         prdata = rd[t];
         tick();
         chk($sformatf("rr_rvalid%0d", t), 64'(resp_valid),
             64'(1 << (t % 2)));
         chk($sformatf("rr_rdata%0d", t), 64'(resp_rdata), 64'(rd[t]));
      end
      req_valid = 2'b00; tick(); tick();

      // Read with three wait states from req0
      set_req(0, 1'b0, 32'h30, 32'h0);
      req_valid = 2'b01; #1;
      chk("ws_ready", 64'(req_ready), 64'h1);
      tick(); req_valid = 2'b00; pready = 1'b0;
      tick();
      for (int c = 2; c <= 5; c++) begin
         if (c == 5) begin pready = 1'b1; prdata = 32'hDEAD_BEEF; end
         chk($sformatf("ws_pstb%0d", c), 64'({psel, penable}), 64'h3);
         chk($sformatf("ws_paddr%0d", c), 64'(paddr), 64'h30);
         chk($sformatf("ws_rv%0d", c), 64'(resp_valid), 64'h0);
         tick();
      end
      chk("ws_rvalid_c6", 64'(resp_valid), 64'h1);
      chk("ws_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);

      // Write from req1 ending in slave error, then clean read from req0
      set_req(1, 1'b1, 32'h40, 32'h55);
      pslverr = 1'b1; req_valid = 2'b10; #1;
      chk("err_ready", 64'(req_ready), 64'h2);
      tick(); req_valid = 2'b00;
      tick(); tick();
      chk("err_rvalid", 64'(resp_valid), 64'h2);
      chk("err_slverr", 64'(resp_slverr), 64'h1);
      chk("err_rdata", 64'(resp_rdata), 64'h0);
      pslverr = 1'b0; prdata = 32'h77;
      set_req(0, 1'b0, 32'h44, 32'h0);
      req_valid = 2'b01; #1;
      chk("ok_ready", 64'(req_ready), 64'h1);
      tick(); req_valid = 2'b00;
      tick(); tick();
      chk("ok_rvalid", 64'(resp_valid), 64'h1);
      chk("ok_slverr", 64'(resp_slverr), 64'h0);
      chk("ok_rdata", 64'(resp_rdata), 64'h77);

      // Stalled ACCESS with pready held low
      pready = 1'b0; prdata = 32'hFFFF_FFFF;
      set_req(0, 1'b0, 32'h50, 32'h0);
      req_valid = 2'b01; #1;
      chk("st_ready", 64'(req_ready), 64'h1);
      tick(); req_valid = 2'b00;
      tick();
`ifdef APB_ARB_TIMEOUT_EN
      for (int c = 2; c <= 5; c++) begin
         chk($sformatf("to_pen%0d", c), 64'({psel, penable}), 64'h3);
         tick();
      end
      chk("to_rvalid", 64'(resp_valid), 64'h1);
      chk("to_slverr", 64'(resp_slverr), 64'h1);
      chk("to_rdata", 64'(resp_rdata), 64'h0);
      chk("to_idle", 64'({psel, penable}), 64'h0);
      req_valid = 2'b01; #1;
      chk("to_ready2", 64'(req_ready), 64'h1);
      tick(); req_valid = 2'b00;
      tick();
`else
      seen = 1'b0;
      for (int c = 0; c < 21; c++) begin
         tick();
         if (resp_valid !== 2'b00) seen = 1'b1;
      end
      chk("st_hold", 64'({psel, penable}), 64'h3);
      chk("st_noresp", 64'(seen), 64'h0);
`endif

      // Reset for one edge while in ACCESS
      chk("rs_in_access", 64'({psel, penable}), 64'h3);
      aresetn = 1'b0; tick(); aresetn = 1'b1;
      chk_all_zero("rs_mid");
      set_req(1, 1'b0, 32'h60, 32'h0);
      req_valid = 2'b10; #1;
      chk("rs_ready_req1", 64'(req_ready), 64'h2);
      tick(); req_valid = 2'b00;
      chk("rs_no_resp", 64'(resp_valid), 64'h0);
      chk("rs_paddr", 64'(paddr), 64'h60);
      pready = 1'b1; prdata = 32'h99;
      tick(); tick();
      chk("rs_rvalid", 64'(resp_valid), 64'h2);
      chk("rs_rdata", 64'(resp_rdata), 64'h99);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
